product_bcd_converter: RTL and testbench
========================================

// Module: product_bcd_converter
// PURPOSE
//  Downstream stage of the signed sequential multiplier. Captures the finished
//  16-bit two's-complement product and converts it to sign + 5 BCD digits with
//  sequential double-dabble (one bit per clock) for the display/readout logic.
//  Results are held stable until the next conversion or reset.
// PARAMETERS
//  PROD_W   16  product width in bits, two's complement
//  DIGITS   5   BCD digits; must satisfy 10^DIGITS > 2^(PROD_W-1)
// PORTS
//  clk      in   1           rising-edge clock
//  rst      in   1           async active-high reset
//  start    in   1           capture product and begin; honoured only when ready=1
//  product  in   PROD_W      signed product from multiplier datapath; sampled with start
//  ready    out  1           1 in IDLE or DONE; start accepted this cycle
//  busy     out  1           1 while converting (SHIFT state)
//  done     out  1           single-cycle pulse: neg/bcd valid and updated
//  neg      out  1           1 if captured product < 0
//  bcd      out  4*DIGITS    magnitude, digit 0 (units) in bits [3:0]
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, neg=0,
//   bcd=0, internal shift reg/scratch/counter=0. Mid-conversion rst aborts;
//   no done pulse follows.
//  States: IDLE, SHIFT, DONE.
//   IDLE: start=1 -> capture mag=|product| (PROD_W-bit unsigned; 0x8000 ->
//    32768, no overflow), neg_pend=product[PROD_W-1], scratch=0, cnt=0 -> SHIFT.
//   SHIFT: each edge, every scratch digit >=5 gets +3 (bcd_add3), then
//    {scratch,mag} shifts left 1; cnt++. On the edge where cnt reaches PROD_W,
//    load bcd<=final scratch, neg<=neg_pend -> DONE.
//   DONE: done=1 for exactly this cycle. start=1 here -> same capture as
//    IDLE, next state SHIFT (back-to-back); else -> IDLE.
//  Latency: start sampled at edge N -> done high in the cycle after edge N+PROD_W
//   (PROD_W+1 edges; 17 at default). Throughput one result per PROD_W+1 clocks.
//  start while busy=1: ignored, product not re-sampled, run unaffected.
//  neg/bcd change only at the DONE-entry edge; stable otherwise (incl. SHIFT).
//  Zero product: neg=0. neg uses product MSB only; no negative zero possible.
//  cnt width clog2(PROD_W+1); no wrap in legal operation.
// STRUCTURE
//  Shared package: state encoding (IDLE/SHIFT/DONE), BCD_DIGIT_W=4, ADD3
//   threshold constant 5, default PROD_W/DIGITS.
//  One sub-module: bcd_add3 (combinational 4-bit: out = in>=5 ? in+3 : in),
//   instantiated DIGITS times in a generate loop; FSM, shifter, counter at top.
// TESTING
//  product=0x0000, start 1 cycle -> done after 17 edges, neg=0, bcd=0x00000.
//  product=0xC000 (-16384) -> neg=1, bcd=0x16384; 0x7FFF -> neg=0, bcd=0x32767.
//  product=0x8000 -> neg=1, bcd=0x32768; 0xFFFF -> neg=1, bcd=0x00001.
//  start=1 with 0x0005 at cycle 3 of a run of 0x0064 -> single done, bcd=0x00100.
//  rst asserted mid-SHIFT -> all outputs 0 immediately, no done; next start works.
//  start held in DONE with 0x0010 after 0x0009 -> two done pulses 17 edges apart,
//   bcd 0x00009 then 0x00016; bcd stable between pulses.

Source files
------------

// File: rtl/product_bcd_converter_pkg.sv
// Shared constants for the product-to-BCD readout stage.
package product_bcd_converter_pkg;

  localparam int PROD_W_DEF  = 16;
  localparam int DIGITS_DEF  = 5;
  localparam int BCD_DIGIT_W = 4;

  // Digits at or above this value get +3 before each shift.
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_VALUE  = 4'd3;

  // Converter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/product_bcd_converter_add3.sv
// One double-dabble correction cell: pre-adjusts a BCD digit so that the
// following left shift carries correctly into the next decade.
module bcd_add3
  import product_bcd_converter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Add 3 when the digit would overflow past 9 after doubling
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADD3_THRESH) digit_o = digit_i + ADD3_VALUE;
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Captures a signed product and converts its magnitude to packed BCD with a
// bit-serial double-dabble, one product bit per clock. Sign and digits are
// published together on entry to DONE and held until the next result.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | converting, one magnitude bit per clock
// DONE  | result just published; done pulse; may accept a new start
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PROD_W-1:0]             product,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic                          neg,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(PROD_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PROD_W - 1);
  localparam logic [PROD_W-1:0] ONE_P    = {{(PROD_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [PROD_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_pend_q, neg_pend_d;
  logic              neg_q, neg_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              accept;

  // Per-digit +3 correction applied to the scratch before every shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign neg    = neg_q;
  assign bcd    = bcd_q;
  assign accept = ready && start;

  // Next-state, capture and shift logic
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
    bcd_d      = bcd_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          // Unsigned magnitude: the most negative value maps onto itself,
          // which read as unsigned is exactly its magnitude.
          mag_d      = product[PROD_W-1] ? (~product + ONE_P) : product;
          neg_pend_d = product[PROD_W-1];
          scratch_d  = '0;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], mag_q[PROD_W-1]};
        mag_d     = {mag_q[PROD_W-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bcd_d   = scratch_d;
          neg_d   = neg_pend_q;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mag_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
      bcd_q      <= bcd_d;
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter with hand-computed BCD results.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] product;
  logic        ready, busy, done, neg;
  logic [19:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;
  int pulses;
  bit changed;

  product_bcd_converter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .product (product),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .neg     (neg),
    .bcd     (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the capture edge; returns edge count including that edge,
  // and flags any change of neg/bcd before done shows up.
  task automatic wait_done(output int n, output bit chg);
    logic [19:0] ref_bcd;
    logic        ref_neg;
    ref_bcd = bcd;
    ref_neg = neg;
    chg = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (!done && (bcd !== ref_bcd || neg !== ref_neg)) chg = 1'b1;
    end
  endtask

  task automatic count_done(input int cycles, output int p);
    p = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) p++;
    end
  endtask

  task automatic do_conv(input logic [15:0] p, input logic neg_e, input logic [19:0] bcd_e,
                         input string tag);
    int  n;
    bit  chg;
    start = 1'b1; product = p;
    @(posedge clk); #1;
    start = 1'b0; product = 16'h0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(n, chg);
    chk({tag, "_lat"}, n, 32'd17);
    chk({tag, "_held"}, {31'd0, chg}, 32'd0);
    chk({tag, "_neg"}, {31'd0, neg}, {31'd0, neg_e});
    chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, bcd_e});
    chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_keep"}, {12'd0, bcd}, {12'd0, bcd_e});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; product = 16'h0;
    #3;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_neg",   {31'd0, neg},   32'd0);
    chk("rst_bcd",   {12'd0, bcd},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_conv(16'h0000, 1'b0, 20'h00000, "zero");
    do_conv(16'hC000, 1'b1, 20'h16384, "m16384");
    do_conv(16'h7FFF, 1'b0, 20'h32767, "max_pos");
    do_conv(16'h8000, 1'b1, 20'h32768, "min_neg");

    // start during SHIFT must be ignored
    start = 1'b1; product = 16'h0064;
    @(posedge clk); #1;
    start = 1'b0; product = 16'h0;
    edges = 1;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; edges++; end
    start = 1'b1; product = 16'h0005;
    @(posedge clk); #1;
    start = 1'b0; product = 16'h0;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    begin
      int n; bit chg;
      wait_done(n, chg);
      chk("ign_lat", n + edges, 32'd17);
    end
    chk("ign_bcd", {12'd0, bcd}, 32'h00100);
    chk("ign_neg", {31'd0, neg}, 32'd0);
    count_done(20, pulses);
    chk("ign_single", pulses, 32'd0);

    // re-establish neg=1 and a nonzero bcd, then reset mid-SHIFT
    do_conv(16'h8000, 1'b1, 20'h32768, "pre_rst");
    start = 1'b1; product = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0; product = 16'h0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("mrst_ready", {31'd0, ready}, 32'd1);
    chk("mrst_busy",  {31'd0, busy},  32'd0);
    chk("mrst_done",  {31'd0, done},  32'd0);
    chk("mrst_neg",   {31'd0, neg},   32'd0);
    chk("mrst_bcd",   {12'd0, bcd},   32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    count_done(25, pulses);
    chk("mrst_nodone", pulses, 32'd0);
    do_conv(16'hFFFF, 1'b1, 20'h00001, "m1");

    // back-to-back with start held through the DONE cycle
    start = 1'b1; product = 16'h0009;
    @(posedge clk); #1;
    product = 16'h0010;
    begin
      int n; bit chg;
      wait_done(n, chg);
      chk("b2b1_lat",  n, 32'd17);
      chk("b2b1_held", {31'd0, chg}, 32'd0);
      chk("b2b1_bcd",  {12'd0, bcd}, 32'h00009);
      chk("b2b1_rdy",  {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0; product = 16'h0;
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      wait_done(n, chg);
      chk("b2b2_lat",  n, 32'd17);
      chk("b2b2_held", {31'd0, chg}, 32'd0);
      chk("b2b2_bcd",  {12'd0, bcd}, 32'h00016);
      chk("b2b2_neg",  {31'd0, neg}, 32'd0);
    end
    @(posedge clk); #1;
    chk("end_idle", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
